// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the fetch stage: opcode constants, instruction field
// positions, the prefetch entry layout and the fetch control-state encoding.
package fetch_prefetch_queue_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned OPC_MSB      = 31;
  localparam int unsigned OPC_LSB      = 26;
  localparam int unsigned FETCH_ADDR_W = 8;

  localparam logic [5:0] OPC_HALT = 6'b111111;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_JAL  = 6'b000011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_BNE  = 6'b000101;

  typedef struct packed {
    logic [INSTR_W-1:0]      ir;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// Synchronous prefetch FIFO with single-cycle flush; flush wins over push/pop.
module fetch_fifo #(
  parameter int unsigned W     = 40,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_eff;

  always_comb begin
    pop_eff = pop_i && (count_q != '0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i)  wptr_d = wptr_q + AW'(1);
      if (pop_eff) rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && !pop_eff && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch with prefetch FIFO, redirect flush and halt stop.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_flushes counters.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk1,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_ir,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushes,
`endif
  output fetch_state_e      dbg_state
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;
  localparam int unsigned EW = 32 + ADDR_W;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]     out_q, out_d;
  logic [OW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     count;
  logic [SW-1:0]     occ;
  logic [EW-1:0]     head;
  logic              fire, keep, halt_hit, pop;

  assign dec_valid     = (count != '0);
  assign dec_ir        = dec_valid ? head[EW-1:ADDR_W] : '0;
  assign dec_pc        = dec_valid ? head[ADDR_W-1:0] : '0;
  assign imem_req_addr = pc_q;
  assign dbg_state     = state_q;

  // Issue only while buffer space covers every read already in flight.
  always_comb begin
    occ            = SW'(count) + SW'(out_q);
    imem_req_valid = (state_q == FS_RUN) && !redirect_valid &&
                     (occ < SW'(DEPTH)) && (out_q < OW'(MAX_OUT));
    fire           = imem_req_valid && imem_req_ready;
    keep           = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    halt_hit       = keep && (opcode_of(imem_rsp_data) == OPC_HALT);
    pop            = dec_valid && dec_ready && !redirect_valid;
    out_d          = out_q + OW'(fire) - OW'(imem_rsp_valid);
    pc_d           = fire ? pc_q + ADDR_W'(1) : pc_q;
    rsp_pc_d       = keep ? rsp_pc_q + ADDR_W'(1) : rsp_pc_q;
    drop_d         = drop_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      drop_d   = out_q - OW'(imem_rsp_valid);
    end else if (halt_hit) begin
      drop_d = out_d;
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - OW'(1);
    end
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state_q <= FS_IDLE;
      halted  <= 1'b0;
    end else if (redirect_valid) begin
      state_q <= FS_RUN;
      halted  <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE: state_q <= FS_RUN;
        FS_RUN: if (halt_hit) begin
          state_q <= FS_HALT;
          halted  <= 1'b1;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk1),
    .rst_ni  (reset),
    .flush_i (redirect_valid),
    .push_i  (keep),
    .wdata_i ({imem_rsp_data, rsp_pc_q}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(keep);
      perf_flushes <= perf_flushes + 32'(redirect_valid);
    end
  end
`endif

endmodule
